// File: rtl/expr_gen.sv
// Streams an arithmetic expression (digits joined by '+'/'*') as ASCII characters over a
// valid/ready handshake, evaluating it with '*' precedence as characters are accepted.
module expr_gen (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  num,
    input  logic [31:0] digits,
    input  logic [6:0]  ops,
    input  logic        ready,
    output logic [7:0]  out,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, EMIT_D, EMIT_O, FIN} state_t;

    state_t      state, state_n;
    logic [2:0]  num_r, num_n;
    logic [31:0] digits_r, digits_n;
    logic [7:0]  ops_r, ops_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sum, sum_n;
    logic [7:0]  term, term_n;
    logic        mul_r, mul_n;
    logic [7:0]  out_n, result_n;
    logic        valid_n, busy_n, done_n, err_n;
    logic        bad;
    logic [3:0]  d, nd;
    logic [7:0]  prod;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            num_r    <= '0;
            digits_r <= '0;
            ops_r    <= '0;
            idx      <= '0;
            sum      <= '0;
            term     <= '0;
            mul_r    <= 1'b0;
            out      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_n;
            num_r    <= num_n;
            digits_r <= digits_n;
            ops_r    <= ops_n;
            idx      <= idx_n;
            sum      <= sum_n;
            term     <= term_n;
            mul_r    <= mul_n;
            out      <= out_n;
            valid    <= valid_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
            result   <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        num_n    = num_r;
        digits_n = digits_r;
        ops_n    = ops_r;
        idx_n    = idx;
        sum_n    = sum;
        term_n   = term;
        mul_n    = mul_r;
        out_n    = out;
        valid_n  = valid;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = 1'b0;
        result_n = result;

        bad = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i <= 32'(num) && digits[4*i +: 4] > 4'd9)
                bad = 1'b1;
        end

        d    = digits_r[{idx, 2'b00} +: 4];
        nd   = digits_r[{idx + 3'd1, 2'b00} +: 4];
        prod = 8'(term * {4'h0, d});

        case (state)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        err_n = 1'b1;
                    end else begin
                        // sum = term = 0 with a pending '+' makes d0 load term and leave sum at 0
                        num_n    = num;
                        digits_n = digits;
                        ops_n    = {1'b0, ops};
                        idx_n    = '0;
                        sum_n    = '0;
                        term_n   = '0;
                        mul_n    = 1'b0;
                        out_n    = 8'h30 + {4'h0, digits[3:0]};
                        valid_n  = 1'b1;
                        busy_n   = 1'b1;
                        state_n  = EMIT_D;
                    end
                end
            end
            EMIT_D: begin
                if (ready) begin
                    if (mul_r) begin
                        term_n = prod;
                    end else begin
                        sum_n  = sum + term;
                        term_n = {4'h0, d};
                    end
                    if (idx == num_r) begin
                        valid_n  = 1'b0;
                        done_n   = 1'b1;
                        result_n = sum_n + term_n;
                        state_n  = FIN;
                    end else begin
                        out_n   = ops_r[idx] ? 8'h2A : 8'h2B;
                        state_n = EMIT_O;
                    end
                end
            end
            EMIT_O: begin
                if (ready) begin
                    mul_n   = ops_r[idx];
                    idx_n   = idx + 3'd1;
                    out_n   = 8'h30 + {4'h0, nd};
                    state_n = EMIT_D;
                end
            end
            FIN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
Parameters: none.
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 clr  input  1  Reset; synchronous, active-high.
REQ-003 start  input  1  Request; loads a new expression when the FSM is in IDLE.
REQ-004 num  input  3  Operand count minus one, 0..7, giving 1..8 operands.
REQ-005 digits  input  32  Operand i (0..7) on digits[4i+3:4i], unsigned binary.
REQ-006 ops  input  7  Operator bit i sits between operand i and operand i+1; 0 = '+' (8'h2B), 1 = '*' (8'h2A).
REQ-007 ready  input  1  Downstream can accept the current character.
REQ-008 out  output  8  Current ASCII character.
REQ-009 valid  output  1  out holds a character offered for transfer.
REQ-010 busy  output  1  FSM not in IDLE.
REQ-011 done  output  1  One-cycle pulse after the last character transfers.
REQ-012 result  output  8  Value of the emitted expression, mod 256.
REQ-013 err  output  1  One-cycle pulse when a load is rejected.

Function
REQ-014 FSM states SHALL be IDLE, EMIT_D (digit), EMIT_O (operator) and FIN; all outputs SHALL be registered.
REQ-015 IDLE + start at edge k: num, digits and ops SHALL be captured; the FSM SHALL enter EMIT_D; out SHALL be 8'h30+operand0 and valid = 1 from cycle k+1.
REQ-016 Load check: if any used operand (index ≤ num) is > 9, the block SHALL stay in IDLE, pulse err in cycle k+1, and never assert valid; unused operands SHALL be ignored.
REQ-017 A transfer SHALL occur only on a rising edge with valid & ready both high.
REQ-018 While valid = 1 and ready = 0, out SHALL hold stable and valid SHALL stay 1.
REQ-019 After a transfer, the next character SHALL appear in the following cycle, with no bubble.
REQ-020 Emitted order SHALL be d0, op0, d1, op1, ..., d_num, for 2*num+1 characters total.
REQ-021 A transfer in EMIT_D with operands remaining SHALL move the FSM to EMIT_O; a transfer in EMIT_O SHALL move it to EMIT_D with the next operand.
REQ-022 A transfer of the last digit SHALL move the FSM to FIN: valid = 0 and done = 1 for exactly one cycle, then IDLE.
REQ-023 Evaluation SHALL give '*' precedence over '+' and evaluate left to right.
REQ-024 Evaluation SHALL use two 8-bit accumulators, sum and term, both wrapping mod 256.
REQ-025 On each digit transfer: after '*', term = term*d; otherwise sum = sum+term and term = d; d0 SHALL initialise term = d0 and sum = 0.
REQ-026 result SHALL update to sum+term in the done cycle and SHALL hold until the next accepted start or clr.
REQ-027 busy SHALL be 1 in EMIT_D, EMIT_O and FIN, and 0 in IDLE.
REQ-028 start SHALL be ignored while busy = 1, including in the FIN cycle.
REQ-029 ready SHALL be ignored while valid = 0.

Reset
REQ-030 clr high at an edge SHALL force IDLE and set out = 8'h00, valid = 0, busy = 0, done = 0, err = 0 and result = 8'h00, in the next cycle.
REQ-031 clr SHALL take priority over start and over any transfer at the same edge.
REQ-032 clr mid-stream SHALL abort the stream with no done pulse.
REQ-033 A start in the cycle after clr deasserts SHALL be accepted normally.

Verification
REQ-034 num = 0, digits[3:0] = 7, ready = 1 -> single character 8'h37, then done pulse, result = 7.
REQ-035 "1+2*3": num = 2, digits = 32'h321, ops = 7'b0000010, ready = 1 -> stream 31 2B 32 2A 33 on consecutive cycles, result = 7.
REQ-036 Same as REQ-035, ready low 3 cycles while "+" offered -> out = 8'h2B, valid = 1 held 3 extra cycles; result unchanged at 7.
REQ-037 num = 7, all operands 9, ops = 7'h7F -> 15 characters, result = 8'h41 (9^8 mod 256).
REQ-038 num = 1, digits = 32'hA5 -> err pulse, valid never asserted; num = 0, same digits -> accepted, emits 8'h35.
REQ-039 clr during the third character of REQ-035 -> valid = 0 next cycle, no done; restart then completes with result = 7.
